fifo_ctrl_mm: RTL and testbench
===============================

Name: fifo_ctrl_mm

Overview:
Pointer/flag controller that sequences the 8x10 dual-pointer memory block as a FIFO. It converts requester write/read strobes into the memory's push, pop, wr_ptr and rd_ptr signals, and tracks occupancy. It provides full/empty/almost flags and an overflow/underflow error state. It sits between the upstream producer/downstream consumer and the memory instance.

Parameters:
MEM_SIZE, 8, memory depth in words; must equal 2**PTR
WORD_SIZE, 10, data word width
PTR, 3, pointer width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
init  input  1  synchronous (re)initialise and threshold-load request
th_af  input  PTR+1  almost-full threshold (loaded in INIT)
th_ae  input  PTR+1  almost-empty threshold (loaded in INIT)
fifo_wr  input  1  write request from producer
fifo_rd  input  1  read request from consumer
data_in  input  WORD_SIZE  write data
data_in_MM  output  WORD_SIZE  write data to memory; combinational copy of data_in
push  output  1  memory write enable (combinational)
pop  output  1  memory read enable (combinational)
wr_ptr  output  PTR  memory write address (registered)
rd_ptr  output  PTR  memory read address (registered)
valid_out  output  1  memory data_out valid (registered; pop delayed 1 cycle)
fifo_count  output  PTR+1  occupancy 0..MEM_SIZE (registered)
full, empty  output  1  count==MEM_SIZE / count==0 (combinational from count)
almost_full  output  1  count >= th_af_reg
almost_empty  output  1  count <= th_ae_reg
error  output  1  sticky overflow/underflow flag
state  output  2  INIT=0, IDLE=1, ACTIVE=2, ERROR=3

Behaviour:
- Reset values: state=INIT, wr_ptr=0, rd_ptr=0, fifo_count=0, valid_out=0, error=0, th_af_reg=MEM_SIZE-1, th_ae_reg=1. Consequently push=0, pop=0, empty=1, full=0, almost_empty=1, almost_full=0.
- Reset asserted mid-operation: immediately forces the reset values; memory contents are not cleared.
- init=1 in any state: next state INIT; pointers, count and error are cleared; th_af/th_ae are captured into th_af_reg/th_ae_reg.
- INIT: push=pop=0. Thresholds are reloaded every cycle while init=1. Leaves to IDLE on the first cycle with init=0.
- push/pop are active only in IDLE/ACTIVE:
  - push = fifo_wr & ~full
  - pop = fifo_rd & ~empty
- On an accepted push: wr_ptr <= wr_ptr+1, wrapping 7->0.
- On an accepted pop: rd_ptr <= rd_ptr+1, wrapping 7->0.
- Count update: push & ~pop -> +1; pop & ~push -> -1; both or neither -> unchanged.
- Simultaneous read+write when not full and not empty: both performed; count unchanged.
- valid_out: registered copy of pop; memory read data is valid the cycle after pop.
- Overflow: fifo_wr while full (see macro for the concurrent-read case) -> write dropped, error<=1, next state ERROR.
- Underflow: fifo_rd while empty -> pop=0, error<=1, next state ERROR. A concurrent accepted write still completes.
- ERROR: push=pop=0; flags and count frozen. Exit only via reset or init.
- IDLE<->ACTIVE: next state ACTIVE if next count>0, else IDLE.
- Threshold inputs are ignored outside INIT.

Optional Feature:
FIFO_FULL_RW_EN:
- Defined: fifo_wr & fifo_rd while full -> both push and pop asserted; count stays MEM_SIZE; no error.
- Undefined: same case -> pop performed, write dropped, overflow error raised, state ERROR.

Test Plan:
- Reset then init=1 with th_af=6, th_ae=2, then init=0 -> state INIT->IDLE; empty=1, almost_empty=1, fifo_count=0, pointers 0.
- 8 consecutive writes of 0x2AC, 0x295, ... -> wr_ptr 0..7 then 0; fifo_count=8, full=1; almost_full asserts when count reaches 6; a 9th write -> push=0, error=1, state ERROR.
- From 3 stored words, 3 reads -> pop each cycle; valid_out one cycle later; rd_ptr 0->3; empty=1 afterward; a 4th read -> error=1, state ERROR; init=1 clears error.
- Count=4 with fifo_wr=fifo_rd=1 for 5 cycles -> count stays 4; both pointers advance by 5 and wrap (e.g. 4->1).
- Full plus simultaneous wr/rd -> with FIFO_FULL_RW_EN: count=8, no error; without it: count=7, error=1.
- Assert reset mid-burst at count=5 -> all outputs return to reset values immediately; state INIT.

Source files
------------

// File: rtl/fifo_ctrl_mm.sv
// Pointer/flag controller that runs an 8x10 dual-pointer memory as a FIFO.
// Define FIFO_FULL_RW_EN to allow a simultaneous write+read while full.
module fifo_ctrl_mm #(
   parameter int MEM_SIZE  = 8,
   parameter int WORD_SIZE = 10,
   parameter int PTR       = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic [PTR:0]         th_af,
   input  logic [PTR:0]         th_ae,
   input  logic                 fifo_wr,
   input  logic                 fifo_rd,
   input  logic [WORD_SIZE-1:0] data_in,
   output logic [WORD_SIZE-1:0] data_in_MM,
   output logic                 push,
   output logic                 pop,
   output logic [PTR-1:0]       wr_ptr,
   output logic [PTR-1:0]       rd_ptr,
   output logic                 valid_out,
   output logic [PTR:0]         fifo_count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 error,
   output logic [1:0]           state
);

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_IDLE   = 2'd1,
      S_ACTIVE = 2'd2,
      S_ERROR  = 2'd3
   } state_t;

   localparam logic [PTR:0] FULL_CNT = (PTR+1)'(MEM_SIZE);

   state_t       state_q;
   state_t       state_d;
   logic [PTR:0] count_d;
   logic [PTR:0] th_af_reg;
   logic [PTR:0] th_ae_reg;
   logic         active;
   logic         overflow;
   logic         underflow;

   assign state        = state_q;
   assign data_in_MM   = data_in;
   assign full         = (fifo_count == FULL_CNT);
   assign empty        = (fifo_count == '0);
   assign almost_full  = (fifo_count >= th_af_reg);
   assign almost_empty = (fifo_count <= th_ae_reg);
   assign active       = (state_q == S_IDLE) || (state_q == S_ACTIVE);

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   // Output logic: memory strobes and error detection.
   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      push      = 1'b0;
      pop       = 1'b0;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (active) begin
         pop       = fifo_rd & ~empty;
         underflow = fifo_rd & empty;
`ifdef FIFO_FULL_RW_EN
         // A read in the same cycle frees the slot the write lands in.
         push      = fifo_wr & (~full | fifo_rd);
         overflow  = fifo_wr & full & ~fifo_rd;
`else
         push      = fifo_wr & ~full;
         overflow  = fifo_wr & full;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      count_d = fifo_count;
      if (push && !pop)      count_d = fifo_count + 1'b1;
      else if (pop && !push) count_d = fifo_count - 1'b1;

      state_d = state_q;
      case (state_q)
         S_INIT:           state_d = S_IDLE;
         S_IDLE, S_ACTIVE: begin
            if (overflow || underflow) state_d = S_ERROR;
            else if (count_d != '0)    state_d = S_ACTIVE;
            else                       state_d = S_IDLE;
         end
         default:          state_d = S_ERROR;
      endcase
      if (init) state_d = S_INIT;
   end

   // Pointers, occupancy, thresholds and the sticky error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         valid_out  <= 1'b0;
         error      <= 1'b0;
         th_af_reg  <= FULL_CNT - 1'b1;
         th_ae_reg  <= (PTR+1)'(1);
      end else begin
         valid_out <= pop;
         if (init) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            error      <= 1'b0;
            th_af_reg  <= th_af;
            th_ae_reg  <= th_ae;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_d;
            if (overflow || underflow) error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_mm.sv
// Table-driven bench for fifo_ctrl_mm; expected values are hand-derived per vector.
// Expectations for the full write+read case follow FIFO_FULL_RW_EN.
module tb_fifo_ctrl_mm;

   logic       clk = 1'b0;
   logic       reset;
   logic       init;
   logic [3:0] th_af;
   logic [3:0] th_ae;
   logic       fifo_wr;
   logic       fifo_rd;
   logic [9:0] data_in;
   logic [9:0] data_in_MM;
   logic       push;
   logic       pop;
   logic [2:0] wr_ptr;
   logic [2:0] rd_ptr;
   logic       valid_out;
   logic [3:0] fifo_count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       error;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_ctrl_mm dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .th_af        (th_af),
      .th_ae        (th_ae),
      .fifo_wr      (fifo_wr),
      .fifo_rd      (fifo_rd),
      .data_in      (data_in),
      .data_in_MM   (data_in_MM),
      .push         (push),
      .pop          (pop),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .valid_out    (valid_out),
      .fifo_count   (fifo_count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error),
      .state        (state)
   );

   typedef struct {
      logic       init;
      logic       wr;
      logic       rd;
      logic [9:0] data;
      logic       push;
      logic       pop;
      logic [1:0] st;
      logic [3:0] cnt;
      logic [2:0] wp;
      logic [2:0] rp;
      logic       valid;
      logic       full;
      logic       empty;
      logic       af;
      logic       ae;
      logic       err;
   } vec_t;

   vec_t vecs[$];
   int   vec_no = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic i_init, input logic i_wr, input logic i_rd, input logic [9:0] i_data,
                      input logic e_push, input logic e_pop, input logic [1:0] e_st, input logic [3:0] e_cnt,
                      input logic [2:0] e_wp, input logic [2:0] e_rp, input logic e_valid, input logic e_full,
                      input logic e_empty, input logic e_af, input logic e_ae, input logic e_err);
      vec_t v;
      v = '{i_init, i_wr, i_rd, i_data, e_push, e_pop, e_st, e_cnt, e_wp, e_rp,
            e_valid, e_full, e_empty, e_af, e_ae, e_err};
      vecs.push_back(v);
   endtask

   // Apply each queued vector: strobes checked mid-cycle, registers checked after the edge.
   task automatic run_vecs();
      foreach (vecs[i]) begin
         @(negedge clk);
         init    = vecs[i].init;
         th_af   = vecs[i].init ? 4'd6 : 4'd3;
         th_ae   = vecs[i].init ? 4'd2 : 4'd5;
         fifo_wr = vecs[i].wr;
         fifo_rd = vecs[i].rd;
         data_in = vecs[i].data;
         #1;
         check($sformatf("v%0d push", vec_no), 16'(push), 16'(vecs[i].push));
         check($sformatf("v%0d pop", vec_no), 16'(pop), 16'(vecs[i].pop));
         check($sformatf("v%0d data_in_MM", vec_no), 16'(data_in_MM), 16'(vecs[i].data));
         @(posedge clk);
         #1;
         check($sformatf("v%0d state", vec_no), 16'(state), 16'(vecs[i].st));
         check($sformatf("v%0d fifo_count", vec_no), 16'(fifo_count), 16'(vecs[i].cnt));
         check($sformatf("v%0d wr_ptr", vec_no), 16'(wr_ptr), 16'(vecs[i].wp));
         check($sformatf("v%0d rd_ptr", vec_no), 16'(rd_ptr), 16'(vecs[i].rp));
         check($sformatf("v%0d valid_out", vec_no), 16'(valid_out), 16'(vecs[i].valid));
         check($sformatf("v%0d full", vec_no), 16'(full), 16'(vecs[i].full));
         check($sformatf("v%0d empty", vec_no), 16'(empty), 16'(vecs[i].empty));
         check($sformatf("v%0d almost_full", vec_no), 16'(almost_full), 16'(vecs[i].af));
         check($sformatf("v%0d almost_empty", vec_no), 16'(almost_empty), 16'(vecs[i].ae));
         check($sformatf("v%0d error", vec_no), 16'(error), 16'(vecs[i].err));
         vec_no++;
      end
      vecs.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " state"}, 16'(state), 16'd0);
      check({tag, " fifo_count"}, 16'(fifo_count), 16'd0);
      check({tag, " wr_ptr"}, 16'(wr_ptr), 16'd0);
      check({tag, " rd_ptr"}, 16'(rd_ptr), 16'd0);
      check({tag, " valid_out"}, 16'(valid_out), 16'd0);
      check({tag, " error"}, 16'(error), 16'd0);
      check({tag, " push"}, 16'(push), 16'd0);
      check({tag, " pop"}, 16'(pop), 16'd0);
      check({tag, " empty"}, 16'(empty), 16'd1);
      check({tag, " full"}, 16'(full), 16'd0);
      check({tag, " almost_empty"}, 16'(almost_empty), 16'd1);
      check({tag, " almost_full"}, 16'(almost_full), 16'd0);
   endtask

   logic [9:0] words [8] = '{10'h2AC, 10'h295, 10'h17E, 10'h0C3, 10'h3F0, 10'h10F, 10'h255, 10'h0AA};

   initial begin
      // Reset with both strobes high: nothing may reach the memory.
      reset   = 1'b1;
      init    = 1'b0;
      th_af   = 4'd0;
      th_ae   = 4'd0;
      fifo_wr = 1'b1;
      fifo_rd = 1'b1;
      data_in = 10'h000;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      fifo_wr = 1'b0;
      fifo_rd = 1'b0;
      reset   = 1'b0;

      // Init with th_af=6, th_ae=2, then to IDLE.
      add(1,0,0,10'h000, 0,0, 0,0,0,0, 0,0,1,0,1,0);
      add(0,0,0,10'h000, 0,0, 1,0,0,0, 0,0,1,0,1,0);
      // Eight writes to full; almost_full from count 6.
      for (int k = 1; k <= 8; k++)
         add(0,1,0,words[k-1], 1,0, 2,4'(k),3'(k%8),0, 0,(k==8),0,(k>=6),(k<=2),0);
      // Ninth write overflows, then ERROR stays frozen.
      add(0,1,0,10'h155, 0,0, 3,8,0,0, 0,1,0,1,0,1);
      add(0,1,1,10'h0F0, 0,0, 3,8,0,0, 0,1,0,1,0,1);
      // Re-init clears the error.
      add(1,0,0,10'h000, 0,0, 0,0,0,0, 0,0,1,0,1,0);
      add(0,0,0,10'h000, 0,0, 1,0,0,0, 0,0,1,0,1,0);
      // Three writes, three reads, then underflow.
      for (int k = 1; k <= 3; k++)
         add(0,1,0,words[k], 1,0, 2,4'(k),3'(k),0, 0,0,0,0,(k<=2),0);
      for (int j = 1; j <= 3; j++)
         add(0,0,1,10'h000, 0,1, (j==3) ? 2'd1 : 2'd2,4'(3-j),3,3'(j), 1,0,(j==3),0,1,0);
      add(0,0,1,10'h000, 0,0, 3,0,3,3, 0,0,1,0,1,1);
      add(1,0,0,10'h000, 0,0, 0,0,0,0, 0,0,1,0,1,0);
      add(0,0,0,10'h000, 0,0, 1,0,0,0, 0,0,1,0,1,0);
      // Underflow with a concurrent write: the write still lands.
      add(0,1,1,10'h3C3, 1,0, 3,1,1,0, 0,0,0,0,1,1);
      add(1,0,0,10'h000, 0,0, 0,0,0,0, 0,0,1,0,1,0);
      add(0,0,0,10'h000, 0,0, 1,0,0,0, 0,0,1,0,1,0);
      // Count 4, then five simultaneous write+read cycles with pointer wrap.
      for (int k = 1; k <= 4; k++)
         add(0,1,0,words[k+3], 1,0, 2,4'(k),3'(k),0, 0,0,0,0,(k<=2),0);
      for (int i = 1; i <= 5; i++)
         add(0,1,1,words[i], 1,1, 2,4,3'((4+i)%8),3'(i), 1,0,0,0,0,0);
      // Fill to 8, then write+read while full.
      for (int k = 5; k <= 8; k++)
         add(0,1,0,words[k-1], 1,0, 2,4'(k),3'(k-3),5, 0,(k==8),0,(k>=6),0,0);
`ifdef FIFO_FULL_RW_EN
      add(0,1,1,10'h1E1, 1,1, 2,8,6,6, 1,1,0,1,0,0);
`else
      add(0,1,1,10'h1E1, 0,1, 3,7,5,6, 1,0,0,1,0,1);
`endif
      // Build count 5 with valid_out high ahead of a mid-burst reset.
      add(1,0,0,10'h000, 0,0, 0,0,0,0, 0,0,1,0,1,0);
      add(0,0,0,10'h000, 0,0, 1,0,0,0, 0,0,1,0,1,0);
      for (int k = 1; k <= 5; k++)
         add(0,1,0,words[k], 1,0, 2,4'(k),3'(k),0, 0,0,0,0,(k<=2),0);
      add(0,1,1,10'h2AA, 1,1, 2,5,6,1, 1,0,0,0,0,0);
      run_vecs();

      // Asynchronous reset between edges while a write is requested.
      @(negedge clk);
      fifo_wr = 1'b1;
      data_in = 10'h111;
      #2;
      check("pre-reset fifo_count", 16'(fifo_count), 16'd5);
      check("pre-reset valid_out", 16'(valid_out), 16'd1);
      reset = 1'b1;
      #1;
      check_reset_values("mid-reset");
      @(negedge clk);
      fifo_wr = 1'b0;
      reset   = 1'b0;

      // Default thresholds (7/1) must be back; th inputs are ignored without init.
      add(0,0,0,10'h000, 0,0, 1,0,0,0, 0,0,1,0,1,0);
      add(0,1,0,10'h0F1, 1,0, 2,1,1,0, 0,0,0,0,1,0);
      add(0,1,0,10'h0F2, 1,0, 2,2,2,0, 0,0,0,0,0,0);
      run_vecs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
